// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program pointer and status register control, with branch resolution.
// FSM: RUN (accept ops), FLUSH (one-cycle bubble after a taken branch), TRAP (wait for trap_clr).
// Optional feature: define PC_BRANCH_COUNT_EN to add a saturating taken-branch counter (br_count).
module pc_branch_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [2:0]  op_code,
   input  logic        mode,
   input  logic [19:0] jmp_addr,
   input  logic [2:0]  sr_in,
   input  logic        flag_we,
   input  logic        alu_zero,
   input  logic        alu_sign,
   input  logic        alu_carry,
   input  logic        trap_clr,
   output logic [19:0] pc,
   output logic [2:0]  status,
   output logic        flush,
   output logic        trap
`ifdef PC_BRANCH_COUNT_EN
   ,
   output logic [15:0] br_count
`endif
);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_JMP   = 3'd1;
   localparam logic [2:0] OP_JMPZ  = 3'd2;
   localparam logic [2:0] OP_JMPS  = 3'd3;
   localparam logic [2:0] OP_JMPZS = 3'd4;
   localparam logic [2:0] OP_LSR   = 3'd5;
   localparam logic [2:0] OP_XSR   = 3'd6;
   localparam logic [2:0] OP_TRAP  = 3'd7;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [19:0] pc_d;
   logic [2:0]  status_d;
   logic        flush_d;
   logic        trap_mode_q, trap_mode_d;
   logic        accept;
   logic [2:0]  alu_flags;

   // Sequential successor of the pointer; half-word mode keeps a 10-bit pointer.
   function automatic logic [19:0] pc_step(input logic [19:0] cur, input logic full);
      if (full)
         pc_step = cur + 20'd1;
      else
         pc_step = {10'd0, cur[9:0] + 10'd1};
   endfunction

   // Branch target, truncated to 10 bits in half-word mode.
   function automatic logic [19:0] pc_target(input logic [19:0] addr, input logic full);
      if (full)
         pc_target = addr;
      else
         pc_target = {10'd0, addr[9:0]};
   endfunction

   // Branch condition evaluated on the registered status {C,S,Z}.
   function automatic logic is_taken(input logic [2:0] op, input logic [2:0] st);
      case (op)
         OP_JMP:   is_taken = 1'b1;
         OP_JMPZ:  is_taken = st[0];
         OP_JMPS:  is_taken = st[1];
         OP_JMPZS: is_taken = st[0] & st[1];
         default:  is_taken = 1'b0;
      endcase
   endfunction

   assign op_ready  = (state_q == ST_RUN);
   assign trap      = (state_q == ST_TRAP);
   assign accept    = op_valid & op_ready;
   assign alu_flags = {alu_carry, alu_sign, alu_zero};

   // State, pointer, status and flush registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pc          <= 20'd0;
         status      <= 3'd0;
         flush       <= 1'b0;
         trap_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc          <= pc_d;
         status      <= status_d;
         flush       <= flush_d;
         trap_mode_q <= trap_mode_d;
      end
   end

   // Next-state, pointer and status decisions.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc;
      status_d    = status;
      flush_d     = 1'b0;
      trap_mode_d = trap_mode_q;
      case (state_q)
         ST_RUN: begin
            if (flag_we)
               status_d = alu_flags;
            if (accept) begin
               case (op_code)
                  OP_NOP: pc_d = pc_step(pc, mode);
                  OP_LSR: begin
                     status_d = sr_in;
                     pc_d     = pc_step(pc, mode);
                  end
                  OP_XSR: begin
                     status_d = status ^ sr_in;
                     pc_d     = pc_step(pc, mode);
                  end
                  OP_TRAP: begin
                     state_d     = ST_TRAP;
                     trap_mode_d = mode;
                  end
                  default: begin
                     if (is_taken(op_code, status)) begin
                        pc_d    = pc_target(jmp_addr, mode);
                        flush_d = 1'b1;
                        state_d = ST_FLUSH;
                     end else begin
                        pc_d = pc_step(pc, mode);
                     end
                  end
               endcase
            end
         end
         ST_FLUSH: begin
            if (flag_we)
               status_d = alu_flags;
            state_d = ST_RUN;
         end
         ST_TRAP: begin
            if (trap_clr) begin
               state_d = ST_RUN;
               pc_d    = pc_step(pc, trap_mode_q);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

`ifdef PC_BRANCH_COUNT_EN
   // Taken-branch counter: counts RUN->FLUSH transitions, sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         br_count <= 16'd0;
      else if (state_q == ST_RUN && state_d == ST_FLUSH && br_count != 16'hFFFF)
         br_count <= br_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the block's rules.
module tb_pc_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic        mode;
   logic [19:0] jmp_addr;
   logic [2:0]  sr_in;
   logic        flag_we;
   logic        alu_zero, alu_sign, alu_carry;
   logic        trap_clr;
   logic [19:0] pc;
   logic [2:0]  status;
   logic        flush;
   logic        trap;
`ifdef PC_BRANCH_COUNT_EN
   logic [15:0] br_count;
`endif

   pc_branch_unit dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .mode(mode), .jmp_addr(jmp_addr), .sr_in(sr_in),
      .flag_we(flag_we), .alu_zero(alu_zero), .alu_sign(alu_sign),
      .alu_carry(alu_carry), .trap_clr(trap_clr), .pc(pc), .status(status),
      .flush(flush), .trap(trap)
`ifdef PC_BRANCH_COUNT_EN
      , .br_count(br_count)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Behavioural model state
   int       m_pc;
   bit [2:0] m_st;
   bit       m_in_flush;
   bit       m_in_trap;
   bit       m_trap_full;
   int       m_br;

   function automatic int nxt(int p, bit full);
      if (full) return (p + 1) % 1048576;
      return (p % 1024 + 1) % 1024;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"}, {12'd0, pc}, m_pc);
      chk({tag, ".status"}, {29'd0, status}, {29'd0, m_st});
      chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_in_flush});
      chk({tag, ".op_ready"}, {31'd0, op_ready}, {31'd0, !(m_in_flush || m_in_trap)});
      chk({tag, ".trap"}, {31'd0, trap}, {31'd0, m_in_trap});
`ifdef PC_BRANCH_COUNT_EN
      chk({tag, ".br_count"}, {16'd0, br_count}, m_br);
`endif
   endtask

   task automatic mdl_reset();
      m_pc = 0; m_st = 3'd0; m_in_flush = 0; m_in_trap = 0; m_trap_full = 0; m_br = 0;
   endtask

   // Apply one rising edge worth of the block's rules to the model, using current inputs.
   task automatic mdl_edge();
      bit [2:0] nst;
      bit tk;
      if (m_in_trap) begin
         if (trap_clr) begin
            m_in_trap = 0;
            m_pc = nxt(m_pc, m_trap_full);
         end
      end else if (m_in_flush) begin
         m_in_flush = 0;
         if (flag_we) m_st = {alu_carry, alu_sign, alu_zero};
      end else begin
         nst = flag_we ? {alu_carry, alu_sign, alu_zero} : m_st;
         if (op_valid) begin
            case (op_code)
               3'd0: m_pc = nxt(m_pc, mode);
               3'd5: begin nst = sr_in; m_pc = nxt(m_pc, mode); end
               3'd6: begin nst = m_st ^ sr_in; m_pc = nxt(m_pc, mode); end
               3'd7: begin m_in_trap = 1; m_trap_full = mode; end
               default: begin
                  tk = (op_code == 3'd1) || (op_code == 3'd2 && m_st[0]) ||
                       (op_code == 3'd3 && m_st[1]) || (op_code == 3'd4 && m_st[0] && m_st[1]);
                  if (tk) begin
                     m_pc = mode ? int'(jmp_addr) : int'(jmp_addr) % 1024;
                     m_in_flush = 1;
                     if (m_br < 65535) m_br++;
                  end else begin
                     m_pc = nxt(m_pc, mode);
                  end
               end
            endcase
         end
         m_st = nst;
      end
   endtask

   task automatic cyc(input string tag);
      mdl_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Entered at 1 time unit after a rising edge; returns at the same phase.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      mdl_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      check_all({tag, ".hold"});
      rst_n = 1'b1;
   endtask

   task automatic set_op(input bit v, input logic [2:0] op, input bit full, input logic [19:0] addr);
      op_valid = v; op_code = op; mode = full; jmp_addr = addr;
   endtask

   initial begin
      rst_n = 1'b0; op_valid = 0; op_code = 0; mode = 1; jmp_addr = 0; sr_in = 0;
      flag_we = 0; alu_zero = 0; alu_sign = 0; alu_carry = 0; trap_clr = 0;
      #1;
      mdl_reset();
      check_all("reset0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Three NOPs in full mode
      set_op(1, 3'd0, 1, 20'h0);
      for (int i = 1; i <= 3; i++) begin
         cyc("nop");
         chk("nop_pc_lit", {12'd0, pc}, i);
         chk("nop_ready_lit", {31'd0, op_ready}, 32'd1);
      end

      // Half-mode wrap from 0x003FF, full-mode wrap from 0xFFFFF
      set_op(1, 3'd1, 1, 20'h003FF); cyc("jmp3ff");
      cyc("jmp3ff_flush");
      set_op(1, 3'd0, 0, 20'h0); cyc("half_wrap");
      chk("half_wrap_lit", {12'd0, pc}, 32'h0);
      set_op(1, 3'd1, 1, 20'hFFFFF); cyc("jmpfffff");
      cyc("jmpfffff_flush");
      set_op(1, 3'd0, 1, 20'h0); cyc("full_wrap");
      chk("full_wrap_lit", {12'd0, pc}, 32'h0);

      // LSR Z=1, JMPZ taken, JMPS not taken
      sr_in = 3'b001; set_op(1, 3'd5, 1, 20'h0); cyc("lsr");
      set_op(1, 3'd2, 1, 20'hABCDE); cyc("jmpz");
      chk("jmpz_pc_lit", {12'd0, pc}, 32'hABCDE);
      chk("jmpz_flush_lit", {31'd0, flush}, 32'd1);
      chk("jmpz_ready_lit", {31'd0, op_ready}, 32'd0);
      set_op(0, 3'd2, 1, 20'hABCDE); cyc("jmpz_flush");
      set_op(1, 3'd3, 1, 20'h12345); cyc("jmps_nt");
      chk("jmps_pc_lit", {12'd0, pc}, 32'hABCDF);
      chk("jmps_flush_lit", {31'd0, flush}, 32'd0);

      // JMP half mode
      set_op(1, 3'd1, 0, 20'hABCDE); cyc("jmp_half");
      chk("jmp_half_lit", {12'd0, pc}, 32'h000DE);
      set_op(0, 3'd0, 1, 20'h0); cyc("jmp_half_flush");

      // XSR beats a same-edge flag capture
      sr_in = 3'b010; set_op(1, 3'd5, 1, 20'h0); cyc("lsr010");
      sr_in = 3'b111; flag_we = 1; {alu_carry, alu_sign, alu_zero} = 3'b000;
      set_op(1, 3'd6, 1, 20'h0); cyc("xsr");
      chk("xsr_lit", {29'd0, status}, 32'h5);
      flag_we = 0;

      // TRAP at 0x10, ignored ops, trap_clr, reset during TRAP
      set_op(1, 3'd1, 1, 20'h00010); cyc("jmp10");
      set_op(0, 3'd0, 1, 20'h0); cyc("jmp10_flush");
      set_op(1, 3'd7, 1, 20'h0); cyc("trap");
      chk("trap_lit", {31'd0, trap}, 32'd1);
      set_op(1, 3'd1, 1, 20'h55555); flag_we = 1; alu_zero = 1;
      for (int i = 0; i < 5; i++) begin
         cyc("trap_hold");
         chk("trap_hold_pc_lit", {12'd0, pc}, 32'h10);
      end
      flag_we = 0; alu_zero = 0;
      set_op(0, 3'd0, 1, 20'h0); trap_clr = 1; cyc("trap_clr");
      chk("trap_clr_pc_lit", {12'd0, pc}, 32'h11);
      chk("trap_clr_trap_lit", {31'd0, trap}, 32'd0);
      set_op(1, 3'd0, 1, 20'h0); cyc("trap_clr_outside");
      trap_clr = 0;
      set_op(1, 3'd7, 0, 20'h0); cyc("trap2");
      set_op(0, 3'd0, 1, 20'h0);
      do_reset("trap_rst");
      chk("trap_rst_pc_lit", {12'd0, pc}, 32'h0);
      chk("trap_rst_trap_lit", {31'd0, trap}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         op_valid = ($urandom_range(0, 3) != 0);
         op_code  = 3'($urandom_range(0, 7));
         mode     = 1'($urandom_range(0, 1));
         jmp_addr = 20'($urandom);
         sr_in    = 3'($urandom_range(0, 7));
         flag_we  = ($urandom_range(0, 2) == 0);
         {alu_carry, alu_sign, alu_zero} = 3'($urandom_range(0, 7));
         trap_clr = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0)
            do_reset("rnd_rst");
         else
            cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op_valid  in  1  decoder presents an op.
REQ-005 op_ready  out  1  block accepts an op; a transfer is op_valid&op_ready on a rising edge.
REQ-006 op_code  in  3  0 NOP, 1 JMP, 2 JMPZ, 3 JMPS, 4 JMPZS, 5 LSR (load status), 6 XSR (XOR status), 7 TRAP.
REQ-007 mode  in  1  1 = full word (20 bit), 0 = half word (10 bit); sampled with the op.
REQ-008 jmp_addr  in  20  branch target.
REQ-009 sr_in  in  3  {C,S,Z} operand for LSR/XSR.
REQ-010 flag_we  in  1  capture ALU flags this cycle.
REQ-011 alu_zero, alu_sign, alu_carry  in  1 each  ALU result flags.
REQ-012 trap_clr  in  1  leave trap state.
REQ-013 pc  out  20  program pointer, registered.
REQ-014 status  out  3  {C,S,Z} status register, registered.
REQ-015 flush  out  1  one-cycle pulse, registered, on a taken branch.
REQ-016 trap  out  1  high while in TRAP state.

Function
REQ-017 The FSM SHALL have states RUN, FLUSH, TRAP; op_ready = (state==RUN).
REQ-018 NOP/LSR/XSR/not-taken branch accepted in RUN: pc <= pc+1 next edge; state stays RUN.
REQ-019 pc+1 in full mode SHALL wrap 0xFFFFF->0x00000; in half mode pc[9:0] increments with 10-bit wrap and pc[19:10] <= 0.
REQ-020 Taken condition: JMP always; JMPZ if status.Z; JMPS if status.S; JMPZS if Z&S; conditions use the registered status before any same-edge update.
REQ-021 Taken branch: pc <= jmp_addr (full) or {10'b0, jmp_addr[9:0]} (half) next edge; flush=1 and state=FLUSH for exactly one cycle, then RUN.
REQ-022 In FLUSH, pc and status SHALL hold except flag_we capture; ops SHALL NOT be accepted.
REQ-023 LSR: status <= sr_in; XSR: status <= status ^ sr_in; both at the accepting edge.
REQ-024 flag_we in RUN/FLUSH: status <= {alu_carry, alu_sign, alu_zero}; an accepted LSR/XSR on the same edge SHALL take priority over flag_we.
REQ-025 TRAP accepted: pc holds (no increment), state=TRAP, trap=1 from next cycle; flag_we ignored in TRAP.
REQ-026 trap_clr in TRAP: state=RUN next edge, pc <= pc+1 (mode of the TRAP op); trap_clr outside TRAP SHALL be ignored.
REQ-027 op_valid while op_ready=0 SHALL have no effect; the decoder holds the op.

Reset
REQ-028 On rst_n low, immediately: pc=0, status=0, flush=0, state=RUN (op_ready=1, trap=0), br_count=0.
REQ-029 Reset asserted mid-FLUSH or mid-TRAP SHALL abandon the state; first edge after release behaves as RUN.

Configuration
REQ-030 With macro PC_BRANCH_COUNT_EN defined, the block SHALL add output br_count[15:0], incremented once per taken branch, saturating at 0xFFFF.
REQ-031 Without PC_BRANCH_COUNT_EN, br_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, 3 NOPs full mode -> pc 0,1,2,3; op_ready=1 throughout.
REQ-033 pc=0x003FF, NOP half mode -> pc=0x00000; pc=0xFFFFF, NOP full -> 0x00000.
REQ-034 LSR sr_in=3'b001 then JMPZ jmp_addr=0xABCDE full -> pc=0xABCDE, flush=1 one cycle, op_ready=0 that cycle; JMPS same state -> pc+1, no flush.
REQ-035 JMP jmp_addr=0xABCDE half mode -> pc=0x000DE.
REQ-036 XSR sr_in=3'b111 with flag_we=1, alu flags=3'b000, status=3'b010 -> status=3'b101.
REQ-037 TRAP at pc=0x10 -> trap=1, pc=0x10 held, op_valid ignored 5 cycles; trap_clr -> trap=0, pc=0x11; rst_n pulse during TRAP -> pc=0, trap=0.
